// File: rtl/synth_bus_pkg.sv
// Shared types and widths for the synth parameter-memory bus arbiter.
// Imported by the interface, the round-robin picker and the top.
package synth_bus_pkg;

    localparam int ADDR_W = 7;
    localparam int BANK_W = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } bus_state_t;

endpackage

// File: rtl/synth_bus_if.sv
// Requester-side and bus-side signals of the parameter-memory arbiter.
// The slave view belongs to the arbiter, the master view to its users.
interface synth_bus_if #(
    parameter int N_REQ = 3
);
    import synth_bus_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_rw;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*BANK_W-1:0] req_bank;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;

    logic [ADDR_W-1:0]       bus_dec_addr;
    logic [BANK_W-1:0]       bus_bank_adr;
    logic [DATA_W-1:0]       bus_wdata;
    logic                    bus_oe;
    logic                    bus_read_write;
    logic                    bus_write;
    logic                    bus_data_ready;
    logic [DATA_W-1:0]       bus_rdata;
    logic                    busy;

    modport slave (
        input  req, req_rw, req_addr,
        input  req_bank, req_wdata,
        input  bus_rdata,
        output gnt, done, rdata,
        output bus_dec_addr, bus_bank_adr,
        output bus_wdata, bus_oe,
        output bus_read_write, bus_write,
        output bus_data_ready, busy
    );

    modport master (
        output req, req_rw, req_addr,
        output req_bank, req_wdata,
        output bus_rdata,
        input  gnt, done, rdata,
        input  bus_dec_addr, bus_bank_adr,
        input  bus_wdata, bus_oe,
        input  bus_read_write, bus_write,
        input  bus_data_ready, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1
// (mod N_REQ) and returns the first active request as one-hot.
module rr_arbiter #(
    parameter int N_REQ = 3,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int o = 1; o <= N_REQ; o++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] &&
                    ((int'(last) + o) % N_REQ) == j) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/synth_bus_arbiter.sv
// Round-robin owner of the synth parameter bus; every access runs
// SETUP, STROBE, HOLD with all bus outputs registered.
module synth_bus_arbiter
    import synth_bus_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 2
) (
    input logic        CLOCK_50,
    input logic        reset_reg_N,
    synth_bus_if.slave bif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    bus_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  eff;
    logic [N_REQ-1:0]  win;
    logic [N_REQ-1:0]  win_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  done_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [BANK_W-1:0] sel_bank, bank_q;
    logic [DATA_W-1:0] sel_wdata, wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              sel_rw;
    logic              rw_q;
    logic              wr_q;
    logic              dr_q;

    // a requester is masked in its own done cycle
    assign eff = bif.req & ~done_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req  (eff),
        .last (last),
        .gnt  (win)
    );

    always_comb begin
        win_idx   = '0;
        sel_addr  = '0;
        sel_bank  = '0;
        sel_wdata = '0;
        sel_rw    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx   = IDX_W'(i);
                sel_addr  = bif.req_addr[i*ADDR_W +: ADDR_W];
                sel_bank  = bif.req_bank[i*BANK_W +: BANK_W];
                sel_wdata = bif.req_wdata[i*DATA_W +: DATA_W];
                sel_rw    = bif.req_rw[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state   <= IDLE;
            last    <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            bank_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            wr_q    <= 1'b0;
            dr_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            dr_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|eff) begin
                        state   <= SETUP;
                        gnt_q   <= win;
                        win_q   <= win;
                        last    <= win_idx;
                        addr_q  <= sel_addr;
                        bank_q  <= sel_bank;
                        wdata_q <= sel_wdata;
                        rw_q    <= 1'b1;
                        wr_q    <= sel_rw;
                        cnt     <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        dr_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    state <= HOLD;
                    cnt   <= CNT_W'(HOLD_CYC - 1);
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        done_q <= win_q;
                        rw_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        if (!wr_q) rdata_q <= bif.bus_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bif.gnt            = gnt_q;
    assign bif.done           = done_q;
    assign bif.rdata          = rdata_q;
    assign bif.bus_dec_addr   = addr_q;
    assign bif.bus_bank_adr   = bank_q;
    assign bif.bus_wdata      = wdata_q;
    assign bif.bus_oe         = wr_q;
    assign bif.bus_read_write = rw_q;
    assign bif.bus_write      = wr_q;
    assign bif.bus_data_ready = dr_q;
    assign bif.busy           = (state != IDLE);

endmodule

// File: doc/synth_bus_arbiter.md
# synth_bus_arbiter

Shares the synth parameter-memory bus (`dec_addr`, `bank_adr`, data, `data_ready`, `read_write`) among several requesters: the sysex patch loader, the MIDI CC/program-change mapper and the HPS/CPU parameter port. It grants the bus round-robin and sequences each access as SETUP, STROBE, HOLD. Writes and reads cannot collide, and read data is returned to the requester that won. The block sits between the MIDI/sysex front end and the address decoder in the synth controller.

## Interface
- `N_REQ`, 3, number of requesters; index 0 is sysex, 1 is CC, 2 is CPU.
- `SETUP_CYC`, 1, number of address-setup cycles before the strobe (1..15).
- `HOLD_CYC`, 2, number of cycles the address and data stay stable after the strobe (1..15).

- `CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `reset_reg_N`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester access request; held high until that requester's `done`.
- `req_rw`  in  N_REQ  per-requester direction: 1 = write, 0 = read.
- `req_addr`  in  N_REQ*7  flattened 7-bit parameter addresses; requester i uses bits [7i+6:7i].
- `req_bank`  in  N_REQ*3  flattened 3-bit bank addresses.
- `req_wdata`  in  N_REQ*8  flattened write data.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: the request has been latched.
- `done`  out  N_REQ  one-hot, one-cycle pulse: the access has completed.
- `rdata`  out  8  data from the last read; valid with `done`, held until the next read completes.
- `bus_dec_addr`  out  7  parameter address driven onto the bus.
- `bus_bank_adr`  out  3  bank address.
- `bus_wdata`  out  8  write data.
- `bus_oe`  out  1  high while a write is in progress (SETUP through HOLD); drives the tristate enable on `synth_data`.
- `bus_read_write`  out  1  high from SETUP through HOLD of any access.
- `bus_write`  out  1  `bus_read_write` AND write.
- `bus_data_ready`  out  1  one-cycle strobe in the STROBE state.
- `bus_rdata`  in  8  data read back from the bus.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD.
- IDLE
  - The effective request vector is `req & ~done`, so a requester is masked in the cycle its `done` is asserted.
  - If any effective request is present, the rr_arbiter picks the winner, searching upward from `last+1` modulo N_REQ.
  - On a grant, the winner's addr, bank, wdata and rw are latched, `last` is updated to the winner, and the FSM goes to SETUP.
- SETUP: bus outputs are driven from the latched values; counts SETUP_CYC cycles, then goes to STROBE.
- STROBE: one cycle with `bus_data_ready`=1, then goes to HOLD.
- HOLD
  - Counts HOLD_CYC cycles.
  - On a read, `bus_rdata` is captured into `rdata` in the last HOLD cycle.
  - Then goes to IDLE with `done[winner]` pulsed.
- Requests are sampled only in IDLE. If `req` drops mid-access, the access still completes and `done` still pulses.
- The latched request fields are frozen from the grant until return to IDLE; changes on the `req_*` inputs are ignored during that time.
- Requester inputs never reach the bus outputs through combinational logic; all bus outputs are registered.
- Reset state
  - State is IDLE and `last` = N_REQ-1, so requester 0 wins first.
  - `gnt`, `done`, `rdata`, all `bus_*` outputs and `busy` are 0.
- Reset asserted mid-access: all outputs go to 0 immediately and asynchronously. The access is dropped, no `done` is issued, and `rdata` is cleared.
- Counters are 4 bits wide and count down from CYC-1 to 0; they must not wrap.

## Timing
- With defaults, for a request seen in IDLE at cycle N:
  - `gnt` pulses and the bus address becomes valid at N+1 (SETUP).
  - `bus_data_ready` pulses at N+2.
  - HOLD occupies N+3 and N+4.
  - `done` pulses and `rdata` is valid at N+5 (IDLE).
- General latency from request to `done` is SETUP_CYC + HOLD_CYC + 2 cycles.
- Back-to-back accesses: a pending request sampled in the `done` cycle is granted in the next cycle, so bus occupancy per access is SETUP_CYC + HOLD_CYC + 2 cycles with zero idle gap.
- Fairness: with every requester continuously requesting, each requester waits at most (N_REQ-1) accesses.

## Structure
- A shared package `synth_bus_pkg` holds:
  - the state enum `bus_state_t`;
  - the constants ADDR_W=7, BANK_W=3, DATA_W=8 and CNT_W=4.
- One sub-module, `rr_arbiter`, parameterized by N_REQ:
  - purely combinational;
  - inputs: the effective request vector and `last`;
  - output: the one-hot winner.

## Test plan
- Single write: requester 1 writes addr 0x2A, bank 5, data 0x7F. Required:
  - `gnt[1]` at N+1;
  - `bus_dec_addr`=0x2A, `bus_bank_adr`=5, `bus_wdata`=0x7F and `bus_write`=1 from N+1 to N+4;
  - `bus_data_ready` only at N+2;
  - `done[1]` at N+5.
- Single read: requester 2 reads addr 0x10 while `bus_rdata`=0x5A. Required: `bus_oe`=0, `rdata`=0x5A with `done[2]` at N+5, and `rdata` still 0x5A 10 cycles later.
- Contention: all three requesters assert together after reset and hold until each is done. Required:
  - grant order 0, 1, 2;
  - grant cycles N+1, N+6, N+11;
  - a re-asserted `req[0]` is granted after requester 2.
- Same-requester back-to-back: `req[0]` is held high through its `done`. Required: no second grant in the `done` cycle; the next grant is the following cycle only if `req[0]` is still high after `done`.
- Request withdrawal: `req[1]` drops at SETUP. Required: the access still strobes once and `done[1]` pulses at N+5.
- Reset mid-access: `reset_reg_N` is pulled low during STROBE. Required: all outputs are 0 asynchronously, no `done` is issued, and after release requester 0 wins the first contended grant.
